// File: rtl/proc_pkg.sv
// Shared encodings for the 32-bit load/store processor: opcodes, controller states
// and instruction field bit positions, used by the controller, datapath and benches.
package proc_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LW   = 3'b001,
    OP_SW   = 3'b010,
    OP_ADD  = 3'b011,
    OP_HALT = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } ctrl_state_e;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 29;
  localparam int RD_MSB   = 28;
  localparam int RD_LSB   = 24;
  localparam int RS_MSB   = 23;
  localparam int RS_LSB   = 19;
  localparam int RT_MSB   = 18;
  localparam int RT_LSB   = 14;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  // 100/101/110 are the unassigned encodings
  function automatic logic is_legal(input logic [2:0] op);
    return (op == OP_NOP) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADD) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/proc_controller_if.sv
// Memory and register-file port bundle of the processor controller; the controller
// uses the master view, the memory/register-file side uses the slave view.
interface proc_controller_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic [4:0]    rf_raddr_a;
  logic [4:0]    rf_raddr_b;
  logic [DW-1:0] rf_rdata_a;
  logic [DW-1:0] rf_rdata_b;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output rf_raddr_a, rf_raddr_b,
    input  rf_rdata_a, rf_rdata_b,
    output rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  rf_raddr_a, rf_raddr_b,
    output rf_rdata_a, rf_rdata_b,
    input  rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/proc_controller.sv
// Multi-cycle fetch/decode/execute controller for the load/store processor.
// Build option PROC_CTRL_TRAP_EN: illegal opcodes halt the core instead of acting as NOP.
module proc_controller
  import proc_pkg::*;
#(
  parameter int            AW     = 16,
  parameter int            DW     = 32,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  proc_controller_if.master bus,
  output logic [AW-1:0]     pc,
  output logic [DW-1:0]     result,
  output logic              busy,
  output logic              halted
);

`ifdef PROC_CTRL_TRAP_EN
  localparam ctrl_state_e ILLEGAL_NEXT = ST_HALT;
`else
  localparam ctrl_state_e ILLEGAL_NEXT = ST_FETCH;
`endif

  ctrl_state_e   state;
  ctrl_state_e   state_nxt;
  logic [DW-1:0] ir;
  logic [DW-1:0] wb;
  op_e           op;
  logic [4:0]    rd;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [AW-1:0] addr;

  assign op   = op_e'(ir[OP_MSB:OP_LSB]);
  assign rd   = ir[RD_MSB:RD_LSB];
  assign rs   = ir[RS_MSB:RS_LSB];
  assign rt   = ir[RT_MSB:RT_LSB];
  assign addr = AW'(ir[ADDR_MSB:ADDR_LSB]);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALT: if (start) state_nxt = ST_FETCH;
      ST_FETCH:         if (bus.mem_ready) state_nxt = ST_DECODE;
      ST_DECODE:        state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (!is_legal(ir[OP_MSB:OP_LSB])) state_nxt = ILLEGAL_NEXT;
        else if (op == OP_NOP)            state_nxt = ST_FETCH;
        else if (op == OP_HALT)           state_nxt = ST_HALT;
        else                              state_nxt = ST_MEM;
      end
      // ADD spends one idle cycle here so every register write lands in the same slot
      ST_MEM: begin
        if (op == OP_ADD)       state_nxt = ST_WB;
        else if (bus.mem_ready) state_nxt = (op == OP_SW) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_nxt = ST_FETCH;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RST_PC;
      ir     <= '0;
      wb     <= '0;
      result <= '0;
    end else begin
      if (state == ST_FETCH && bus.mem_ready) begin
        ir <= bus.mem_rdata;
        pc <= pc + AW'(1);
      end
      if (state == ST_EXEC && op == OP_ADD) wb <= bus.rf_rdata_a + bus.rf_rdata_b;
      if (state == ST_MEM && op == OP_LW && bus.mem_ready) wb <= bus.mem_rdata;
      if (state == ST_WB) result <= wb;
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.rf_raddr_a = '0;
    bus.rf_raddr_b = '0;
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = '0;
    bus.rf_wdata   = '0;
    busy           = (state != ST_IDLE) && (state != ST_HALT);
    halted         = (state == ST_HALT);
    case (state)
      ST_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = pc;
      end
      ST_DECODE, ST_EXEC, ST_MEM, ST_WB: begin
        bus.rf_raddr_a = rd;
        bus.rf_raddr_b = rs;
        // port A carries rt while the sum is formed, rd (store source) otherwise
        if (state == ST_EXEC && op == OP_ADD) bus.rf_raddr_a = rt;
        if (state == ST_MEM && (op == OP_LW || op == OP_SW)) begin
          bus.mem_req  = 1'b1;
          bus.mem_we   = (op == OP_SW);
          bus.mem_addr = addr;
          if (op == OP_SW) bus.mem_wdata = bus.rf_rdata_a;
        end
        if (state == ST_WB) begin
          bus.rf_we    = 1'b1;
          bus.rf_waddr = rd;
          bus.rf_wdata = wb;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_controller.sv
// Bench for proc_controller: directed and random programs checked against an
// instruction-level reference model (architectural effects plus cycle cost per instruction).
module tb_proc_controller;
  import proc_pkg::*;

  localparam int          AW     = 16;
  localparam int          DW     = 32;
  localparam logic [15:0] RST_PC = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pc;
  logic [31:0] result;
  logic        busy;
  logic        halted;

  proc_controller_if #(.AW(AW), .DW(DW)) bus ();

  proc_controller #(.AW(AW), .DW(DW), .RST_PC(RST_PC)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .result (result),
    .busy   (busy),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // bench-side memory/register file (driven by DUT) and model copies (driven by the model)
  logic [31:0] mem  [0:65535];
  logic [31:0] mmem [0:65535];
  logic [31:0] rf   [0:31];
  logic [31:0] mrf  [0:31];
  logic [15:0] mpc;
  logic [31:0] mres;

  int          lat = 0;
  int          wcnt = 0;
  bit          waiting = 1'b0;
  logic [15:0] hold_addr;
  logic        hold_we;
  logic [31:0] hold_wdata;

  logic [63:0] obs_rfw[$], exp_rfw[$], obs_mw[$], exp_mw[$];
  logic [15:0] obs_rd[$], exp_rd[$];
  int          exp_cycles;
  int          n_assert = 0;
  int          n_fail = 0;

  assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
  assign bus.rf_rdata_b = rf[bus.rf_raddr_b];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory with 'lat' wait cycles per transfer; also logs register writes
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      if (waiting) begin
        check("stable.addr", bus.mem_addr, hold_addr);
        check("stable.we", bus.mem_we, hold_we);
        if (hold_we) check("stable.wdata", bus.mem_wdata, hold_wdata);
      end
      if (wcnt == lat) begin
        bus.mem_ready = 1'b1;
        waiting = 1'b0;
        wcnt = 0;
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          obs_mw.push_back({16'd0, bus.mem_addr, bus.mem_wdata});
          bus.mem_rdata = $urandom;
        end else begin
          bus.mem_rdata = mem[bus.mem_addr];
          obs_rd.push_back(bus.mem_addr);
        end
      end else begin
        if (!waiting) begin
          hold_addr  = bus.mem_addr;
          hold_we    = bus.mem_we;
          hold_wdata = bus.mem_wdata;
        end
        waiting = 1'b1;
        wcnt++;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      waiting = 1'b0;
      wcnt = 0;
    end
    if (bus.rf_we === 1'b1) begin
      rf[bus.rf_waddr] = bus.rf_wdata;
      obs_rfw.push_back({27'd0, bus.rf_waddr, bus.rf_wdata});
    end
  end

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] a);
    return {op, rd, rs, rt, 14'd0} | {16'd0, a};
  endfunction

  task automatic put(input logic [15:0] a, input logic [31:0] d);
    mem[a] = d;
    mmem[a] = d;
  endtask

  task automatic setr(input int r, input logic [31:0] d);
    rf[r] = d;
    mrf[r] = d;
  endtask

  // Instruction-set model: executes from mpc until HALT (or a trapping opcode),
  // recording architectural effects and the cycle at which halted is first seen.
  task automatic model_run();
    int          cyc;
    bit          done;
    logic [31:0] ins, v;
    logic [2:0]  op;
    logic [4:0]  rd, rs, rt;
    logic [15:0] a;
    exp_rfw.delete(); exp_mw.delete(); exp_rd.delete();
    cyc = 1;
    done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      ins = mmem[mpc];
      exp_rd.push_back(mpc);
      mpc = mpc + 16'd1;
      op = ins[31:29]; rd = ins[28:24]; rs = ins[23:19]; rt = ins[18:14]; a = ins[15:0];
      case (op)
        OP_NOP:  cyc += 3 + lat;
        OP_LW: begin
          v = mmem[a];
          exp_rd.push_back(a);
          mrf[rd] = v; mres = v;
          exp_rfw.push_back({27'd0, rd, v});
          cyc += 5 + 2 * lat;
        end
        OP_SW: begin
          mmem[a] = mrf[rd];
          exp_mw.push_back({16'd0, a, mrf[rd]});
          cyc += 4 + 2 * lat;
        end
        OP_ADD: begin
          v = mrf[rs] + mrf[rt];
          mrf[rd] = v; mres = v;
          exp_rfw.push_back({27'd0, rd, v});
          cyc += 5 + lat;
        end
        OP_HALT: begin
          cyc += 3 + lat;
          done = 1'b1;
        end
        default: begin
          cyc += 3 + lat;
`ifdef PROC_CTRL_TRAP_EN
          done = 1'b1;
`endif
        end
      endcase
    end
    exp_cycles = cyc;
  endtask

  task automatic reset_all();
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; mmem[i] = '0; end
    for (int i = 0; i < 32; i++) begin rf[i] = '0; mrf[i] = '0; end
    mpc = RST_PC;
    mres = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_prog(input string tag, input bit poke);
    int n;
    model_run();
    obs_rfw.delete(); obs_mw.delete(); obs_rd.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (halted !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
      start = poke && (n == 3);
    end
    start = 1'b0;
    check({tag, ".cycles"}, n, exp_cycles);
    check({tag, ".halted"}, halted, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".pc"}, pc, mpc);
    check({tag, ".result"}, result, mres);
    check({tag, ".n_rfw"}, obs_rfw.size(), exp_rfw.size());
    for (int i = 0; i < obs_rfw.size() && i < exp_rfw.size(); i++)
      check({tag, ".rfw"}, obs_rfw[i], exp_rfw[i]);
    check({tag, ".n_mw"}, obs_mw.size(), exp_mw.size());
    for (int i = 0; i < obs_mw.size() && i < exp_mw.size(); i++)
      check({tag, ".mw"}, obs_mw[i], exp_mw[i]);
    check({tag, ".n_rd"}, obs_rd.size(), exp_rd.size());
    for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
      check({tag, ".rd"}, obs_rd[i], exp_rd[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    // reset state
    reset_all();
    check("rst.pc", pc, RST_PC);
    check("rst.result", result, 0);
    check("rst.busy", busy, 0);
    check("rst.halted", halted, 0);
    check("rst.mem_req", bus.mem_req, 0);
    check("rst.mem_we", bus.mem_we, 0);
    check("rst.mem_addr", bus.mem_addr, 0);
    check("rst.mem_wdata", bus.mem_wdata, 0);
    check("rst.rf_we", bus.rf_we, 0);
    check("rst.rf_waddr", bus.rf_waddr, 0);
    check("rst.rf_wdata", bus.rf_wdata, 0);
    check("rst.raddr_a", bus.rf_raddr_a, 0);
    check("rst.raddr_b", bus.rf_raddr_b, 0);

    // ADD r1,r2,r3 ; HALT (NOP at 0xFFFF exercises pc wrap)
    setr(2, 5); setr(3, 7);
    put(16'h0000, enc(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0));
    put(16'h0001, enc(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0));
    run_prog("add", 1'b1);
    check("add.r1", rf[1], 12);
    check("add.nwrites", obs_rfw.size(), 1);
    check("add.first_fetch_wrap", obs_rd[1], 16'h0000);

    // SW r2,@0x40 ; LW r4,@0x40 ; HALT, then resume after HALT
    reset_all();
    setr(2, 5); setr(3, 7);
    put(16'h0000, enc(OP_SW, 5'd2, 5'd0, 5'd0, 16'h0040));
    put(16'h0001, enc(OP_LW, 5'd4, 5'd0, 5'd0, 16'h0040));
    put(16'h0002, enc(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0));
    put(16'h0003, enc(OP_ADD, 5'd5, 5'd2, 5'd4, 16'h0));
    put(16'h0004, enc(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0));
    run_prog("swlw", 1'b0);
    check("swlw.mem40", mem[16'h0040], 5);
    check("swlw.r4", rf[4], 5);
    check("swlw.result5", result, 5);
    run_prog("resume", 1'b0);
    check("resume.r5", rf[5], 10);

    // same store/load with three wait cycles per transfer
    reset_all();
    lat = 3;
    setr(2, 5);
    put(16'h0000, enc(OP_SW, 5'd2, 5'd0, 5'd0, 16'h0040));
    put(16'h0001, enc(OP_LW, 5'd4, 5'd0, 5'd0, 16'h0040));
    put(16'h0002, enc(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0));
    run_prog("swlw3", 1'b1);
    check("swlw3.r4", rf[4], 5);

    // store rewrites an instruction before it is fetched
    reset_all();
    lat = 0;
    setr(2, 5); setr(3, 7);
    setr(9, enc(OP_ADD, 5'd6, 5'd2, 5'd3, 16'h0));
    put(16'h0000, enc(OP_SW, 5'd9, 5'd0, 5'd0, 16'h0002));
    put(16'h0001, enc(OP_NOP, 5'd0, 5'd0, 5'd0, 16'h0));
    put(16'h0002, enc(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0));
    put(16'h0003, enc(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0));
    run_prog("smc", 1'b0);
    check("smc.r6", rf[6], 12);

    // illegal opcode 101
    reset_all();
    setr(2, 5); setr(3, 7);
    put(16'h0000, enc(3'b101, 5'd1, 5'd2, 5'd3, 16'h0));
    put(16'h0001, enc(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0));
    put(16'h0002, enc(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0));
    run_prog("illegal", 1'b0);
`ifdef PROC_CTRL_TRAP_EN
    check("illegal.rfw_count", obs_rfw.size(), 0);
`else
    check("illegal.rfw_count", obs_rfw.size(), 1);
`endif

    // reset in the middle of a waiting store
    reset_all();
    lat = 3;
    setr(2, 5);
    put(16'h0040, 32'hDEAD_BEEF);
    put(16'h0000, enc(OP_SW, 5'd2, 5'd0, 5'd0, 16'h0040));
    obs_mw.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (bus.mem_we !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("abort.saw_store", bus.mem_we, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("abort.mem_req", bus.mem_req, 0);
    check("abort.busy", busy, 0);
    check("abort.pc", pc, RST_PC);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort.no_write", obs_mw.size(), 0);
    check("abort.mem40", mem[16'h0040], 32'hDEAD_BEEF);
    check("abort.idle", bus.mem_req, 0);

    // random programs
    for (int t = 0; t < 6; t++) begin
      int          kind;
      logic [31:0] ins;
      reset_all();
      lat = $urandom_range(0, 3);
      for (int r = 0; r < 32; r++) setr(r, $urandom);
      for (int i = 0; i < 8; i++) put(16'h0100 + 16'(i), $urandom);
      for (int i = 0; i < 10; i++) begin
        kind = $urandom_range(0, 4);
        case (kind)
          0: ins = enc(OP_NOP, 5'd0, 5'd0, 5'd0, 16'h0);
          1: ins = enc(OP_LW, 5'($urandom), 5'd0, 5'd0, 16'h0100 + 16'($urandom_range(0, 7)));
          2: ins = enc(OP_SW, 5'($urandom), 5'd0, 5'd0, 16'h0100 + 16'($urandom_range(0, 7)));
          3: ins = enc(OP_ADD, 5'($urandom), 5'($urandom), 5'($urandom), 16'h0);
          default: ins = {3'($urandom_range(4, 6)), 29'($urandom)};
        endcase
        put(16'(i), ins);
      end
      put(16'd10, enc(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0));
      run_prog($sformatf("rnd%0d", t), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
